// File: rtl/ram_port_arbiter.sv
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Shares one dual-port RAM (write port + read port) between
//                requesters A and B using round-robin with bounded bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
    parameter int RAM_WIDTH    = 8,
    parameter int ADDRESS_SIZE = 8,
    parameter int BURST_MAX    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_req,
    input  logic                    a_wr,
    input  logic [ADDRESS_SIZE-1:0] a_addr,
    input  logic [RAM_WIDTH-1:0]    a_wdata,
    output logic                    a_gnt,
    output logic                    a_rvalid,
    output logic [RAM_WIDTH-1:0]    a_rdata,
    input  logic                    b_req,
    input  logic                    b_wr,
    input  logic [ADDRESS_SIZE-1:0] b_addr,
    input  logic [RAM_WIDTH-1:0]    b_wdata,
    output logic                    b_gnt,
    output logic                    b_rvalid,
    output logic [RAM_WIDTH-1:0]    b_rdata,
    output logic                    ram_write_enable,
    output logic [ADDRESS_SIZE-1:0] ram_write_address,
    output logic [RAM_WIDTH-1:0]    ram_data_in,
    output logic                    ram_read_enable,
    output logic [ADDRESS_SIZE-1:0] ram_read_address,
    input  logic [RAM_WIDTH-1:0]    ram_data_out
);

    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_A    = 2'd1;
    localparam logic [1:0] c_OWN_B    = 2'd2;
    localparam logic       c_LAST_A   = 1'b0;
    localparam logic       c_LAST_B   = 1'b1;
    localparam logic [3:0] c_BURST    = 4'(BURST_MAX);
    localparam logic [3:0] c_BEAT_SAT = 4'd15;

    // Port index 0 is the write port, index 1 the read port.
    logic [1:0] w_cand_a;
    logic [1:0] w_cand_b;
    logic [3:0] w_win_all;
    logic [1:0] w_wr_win;
    logic [1:0] w_rd_win;

    assign w_cand_a = {a_req & ~a_wr, a_req & a_wr};
    assign w_cand_b = {b_req & ~b_wr, b_req & b_wr};

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [1:0] r_owner;
        logic [3:0] r_beat;
        logic       r_last;
        logic [1:0] w_win;

        // Grants are suppressed while reset is held so the RAM sees no traffic.
        always_comb begin
            w_win = c_OWN_NONE;
            if (!reset) begin
                if (w_cand_a[p] && !w_cand_b[p]) begin
                    w_win = c_OWN_A;
                end else if (!w_cand_a[p] && w_cand_b[p]) begin
                    w_win = c_OWN_B;
                end else if (w_cand_a[p] && w_cand_b[p]) begin
                    case (r_owner)
                        c_OWN_A: w_win = (r_beat < c_BURST) ? c_OWN_A : c_OWN_B;
                        c_OWN_B: w_win = (r_beat < c_BURST) ? c_OWN_B : c_OWN_A;
                        default: w_win = (r_last == c_LAST_B) ? c_OWN_A : c_OWN_B;
                    endcase
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_owner <= c_OWN_NONE;
                r_beat  <= 4'd0;
                r_last  <= c_LAST_B;
            end else begin
                r_owner <= w_win;
                if (w_win == c_OWN_NONE) begin
                    r_beat <= 4'd0;
                end else if (w_win == r_owner) begin
                    r_beat <= (r_beat == c_BEAT_SAT) ? c_BEAT_SAT : r_beat + 4'd1;
                end else begin
                    r_beat <= 4'd1;
                end
                if (w_win != c_OWN_NONE) begin
                    r_last <= (w_win == c_OWN_B) ? c_LAST_B : c_LAST_A;
                end
            end
        end

        assign w_win_all[2*p +: 2] = w_win;
    end

    assign w_wr_win = w_win_all[1:0];
    assign w_rd_win = w_win_all[3:2];

    assign a_gnt = (w_wr_win == c_OWN_A) || (w_rd_win == c_OWN_A);
    assign b_gnt = (w_wr_win == c_OWN_B) || (w_rd_win == c_OWN_B);

    always_comb begin
        ram_write_enable  = 1'b0;
        ram_write_address = '0;
        ram_data_in       = '0;
        case (w_wr_win)
            c_OWN_A: begin
                ram_write_enable  = 1'b1;
                ram_write_address = a_addr;
                ram_data_in       = a_wdata;
            end
            c_OWN_B: begin
                ram_write_enable  = 1'b1;
                ram_write_address = b_addr;
                ram_data_in       = b_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        ram_read_enable  = 1'b0;
        ram_read_address = '0;
        case (w_rd_win)
            c_OWN_A: begin
                ram_read_enable  = 1'b1;
                ram_read_address = a_addr;
            end
            c_OWN_B: begin
                ram_read_enable  = 1'b1;
                ram_read_address = b_addr;
            end
            default: ;
        endcase
    end

    // rvalid lines up with the RAM's registered data_out.
    logic r_a_rvalid;
    logic r_b_rvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= (w_rd_win == c_OWN_A);
            r_b_rvalid <= (w_rd_win == c_OWN_B);
        end
    end

    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = ram_data_out;
    assign b_rdata  = ram_data_out;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Scoreboard bench for ram_port_arbiter with a behavioural RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, a_wr, b_req, b_wr;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_write_enable, ram_read_enable;
    logic [7:0] ram_write_address, ram_data_in, ram_read_address;
    logic [7:0] ram_data_out = 8'h00;
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    ram_port_arbiter #(.RAM_WIDTH(8), .ADDRESS_SIZE(8), .BURST_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_write_enable(ram_write_enable), .ram_write_address(ram_write_address),
        .ram_data_in(ram_data_in), .ram_read_enable(ram_read_enable),
        .ram_read_address(ram_read_address), .ram_data_out(ram_data_out)
    );

    // Behavioural RAM: registered read, old data on same-address collision.
    always @(posedge clk) begin
        if (ram_write_enable) mem[ram_write_address] <= ram_data_in;
        if (ram_read_enable)  ram_data_out <= mem[ram_read_address];
    end

    typedef struct {
        logic       who;   // 0 = A, 1 = B
        logic [7:0] data;
    } rd_t;

    rd_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest expected read.
    initial begin
        rd_t e;
        forever begin
            @(negedge clk);
            if (a_rvalid || b_rvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rvalid: got a=%b b=%b expected none", a_rvalid, b_rvalid);
                end else begin
                    e = exp_q.pop_front();
                    chk("rvalid_who", {30'd0, a_rvalid, b_rvalid}, e.who ? 32'd1 : 32'd2);
                    chk("rdata", e.who ? {24'd0, b_rdata} : {24'd0, a_rdata}, {24'd0, e.data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
    endtask

    // Checks the combinational bus at the negedge, then advances one cycle.
    task automatic bus(input string tag, input logic ea, input logic eb,
                       input logic we, input logic [7:0] wa, input logic [7:0] wd,
                       input logic re, input logic [7:0] ra);
        @(negedge clk);
        chk({tag, ".a_gnt"}, {31'd0, a_gnt}, {31'd0, ea});
        chk({tag, ".b_gnt"}, {31'd0, b_gnt}, {31'd0, eb});
        chk({tag, ".we"},    {31'd0, ram_write_enable}, {31'd0, we});
        chk({tag, ".waddr"}, {24'd0, ram_write_address}, {24'd0, wa});
        chk({tag, ".wdata"}, {24'd0, ram_data_in}, {24'd0, wd});
        chk({tag, ".re"},    {31'd0, ram_read_enable}, {31'd0, re});
        chk({tag, ".raddr"}, {24'd0, ram_read_address}, {24'd0, ra});
        tick();
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // Both requesters write; A addresses a_base.., B addresses b_base..; data = addr + 0x40.
    task automatic run_pattern(input string tag, input int n, input logic [0:15] breq,
                               input logic [0:15] expa, input logic [7:0] a_base,
                               input logic [7:0] b_base);
        logic [7:0] ap, bp, wa;
        ap = a_base;
        bp = b_base;
        for (int i = 0; i < n; i++) begin
            a_req = 1; a_wr = 1; a_addr = ap; a_wdata = ap + 8'h40;
            b_req = breq[i]; b_wr = 1; b_addr = bp; b_wdata = bp + 8'h40;
            wa = expa[i] ? ap : bp;
            bus($sformatf("%s[%0d]", tag, i), expa[i], breq[i] & ~expa[i], 1'b1, wa, wa + 8'h40, 1'b0, 8'h00);
            if (expa[i]) ap++;
            else if (breq[i]) bp++;
        end
        idle();
    endtask

    initial begin
        logic [7:0] rd_addr [10];
        logic [7:0] rd_data [10];

        idle();
        reset = 1;
        a_req = 1; a_wr = 1; b_req = 1; b_wr = 0; a_addr = 8'h11; b_addr = 8'h22;
        @(negedge clk);
        bus("reset", 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk("reset.rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        idle();
        reset = 0;

        // Write then read back through requester A.
        a_req = 1; a_wr = 1; a_addr = 8'h23; a_wdata = 8'hAA;
        bus("t1_wr", 1, 0, 1, 8'h23, 8'hAA, 0, 8'h00);
        a_wr = 0;
        exp_q.push_back('{who: 1'b0, data: 8'hAA});
        bus("t1_rd", 1, 0, 0, 8'h00, 8'h00, 1, 8'h23);
        idle();
        tick();

        // Contending writes from reset: bursts of four.
        do_reset();
        run_pattern("t2", 12, 16'hFFFF, 16'b1111_0000_1111_0000, 8'h00, 8'h80);
        tick();

        // Preload, then concurrent A write and B read.
        b_req = 1; b_wr = 1; b_addr = 8'h20; b_wdata = 8'h3C;
        bus("t3_pre", 0, 1, 1, 8'h20, 8'h3C, 0, 8'h00);
        a_req = 1; a_wr = 1; a_addr = 8'h10; a_wdata = 8'h55;
        b_wr = 0; b_addr = 8'h20;
        exp_q.push_back('{who: 1'b1, data: 8'h3C});
        bus("t3_both", 1, 1, 1, 8'h10, 8'h55, 1, 8'h20);
        idle();
        a_req = 1; a_wr = 0; a_addr = 8'h10;
        exp_q.push_back('{who: 1'b0, data: 8'h55});
        bus("t3_chk", 1, 0, 0, 8'h00, 8'h00, 1, 8'h10);
        idle();
        tick();

        // Lone reader: ten back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            rd_addr[i] = 8'(i);
            rd_data[i] = 8'(8'h40 + i);
        end
        rd_addr[8] = 8'h23; rd_data[8] = 8'hAA;
        rd_addr[9] = 8'h10; rd_data[9] = 8'h55;
        for (int i = 0; i < 10; i++) begin
            a_req = 1; a_wr = 0; a_addr = rd_addr[i];
            exp_q.push_back('{who: 1'b0, data: rd_data[i]});
            bus($sformatf("t4[%0d]", i), 1, 0, 0, 8'h00, 8'h00, 1, rd_addr[i]);
        end
        idle();
        tick();
        tick();

        // B drops after its second beat; A's new burst starts at beat 1.
        do_reset();
        run_pattern("t5", 11, 16'b1111_1101_1110_0000, 16'b1111_0011_1100_0000, 8'hE0, 8'hF0);
        tick();

        // Reset lands during a B read grant.
        b_req = 1; b_wr = 0; b_addr = 8'h20;
        @(negedge clk);
        chk("t6.pre_b_gnt", {31'd0, b_gnt}, 32'd1);
        #1 reset = 1;
        #1;
        chk("t6.rst_b_gnt", {31'd0, b_gnt}, 32'd0);
        chk("t6.rst_re", {31'd0, ram_read_enable}, 32'd0);
        a_req = 1; a_wr = 1; a_addr = 8'h30; a_wdata = 8'h01;
        bus("t6_hold", 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        reset = 0;
        b_wr = 1; b_addr = 8'h31; b_wdata = 8'h02;
        bus("t6_tie", 1, 0, 1, 8'h30, 8'h01, 0, 8'h00);
        idle();
        repeat (3) tick();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
